mem_req_issue: RTL
==================

Name: mem_req_issue

Overview:
- Data-side memory request issuer, directly downstream of virtual-to-physical address translation in the EX stage.
- Takes the translated physical address, the access attributes and the already-resolved translation exception flag.
- Performs the alignment (ALE) check, generates byte strobes and replicated write data, and drives the SRAM-like data bus.
- Aligns and extends load data, returns it to MEM, and swallows responses belonging to flushed instructions.

Parameters:
ALE_EN, 1, 1 = misaligned half/word access raises ale and is not issued; 0 = no check, low address bits passed through.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  EX holds a memory op; held stable until in_ready
in_we  in  1  1 = store, 0 = load
in_size  in  2  0 = byte, 1 = half, 2 = word (3 treated as word)
in_uns  in  1  zero-extend load result
in_paddr  in  32  translated physical address
in_wdata  in  32  store data, right-aligned
in_ex  in  1  upstream exception (TLB refill/PIL/PIS/PPI/PME, ADEM, or older)
flush  in  1  pipeline flush (ertn/exception commit)
in_ready  out  1  op leaves issue this cycle
ale  out  1  alignment exception for the presented op (combinational)
busy  out  1  state != IDLE
resp_valid  out  1  response available
resp_rdata  out  32  aligned, extended load data; 0 for stores
resp_ready  in  1  MEM accepts response
data_sram_req  out  1  bus request
data_sram_wr  out  1  bus write
data_sram_size  out  2  bus size
data_sram_wstrb  out  4  byte strobes
data_sram_addr  out  32  bus address
data_sram_wdata  out  32  bus write data
data_sram_addr_ok  in  1  request accepted
data_sram_data_ok  in  1  data returned / write done
data_sram_rdata  in  32  read data

Behaviour:
- Reset: state = IDLE. All data_sram_* outputs, resp_valid, resp_rdata and latched fields are 0.
- All data_sram_* outputs are registered. The request stays stable from the first req cycle until addr_ok.
- misaligned = (size 1 && paddr[0]) || (size 2/3 && paddr[1:0] != 0).
- ale = ALE_EN & in_valid & ~in_ex & misaligned & state==IDLE & ~flush.
- Strobes: byte = 4'b0001 << paddr[1:0]; half = 4'b0011 << {paddr[1],0}; word = 4'b1111. Loads present wstrb = 0.
- Write data: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
- Load result: rdata >> (8*addr[1:0]), then the low 8 or 16 bits are sign-extended, or zero-extended if uns. Word is passed unchanged.
- FSM IDLE:
  - flush: nothing latched, in_ready = 0.
  - else in_valid & (in_ex | ale): in_ready = 1 in the same cycle, no request, stay IDLE.
  - else in_valid: latch attributes, set req = 1, go to REQ.
- FSM REQ:
  - in_ready = addr_ok. On addr_ok, clear req.
  - On addr_ok, go to DRAIN if flush is seen in this cycle or any earlier REQ cycle (sticky cancel bit); else go to WAIT.
  - A flush in REQ does not withdraw req.
- FSM WAIT:
  - flush: go to DRAIN; if data_ok arrives in the same cycle, go to IDLE instead.
  - data_ok: capture resp_rdata (0 for stores), set resp_valid = 1, go to RESP.
- FSM RESP:
  - resp_valid is held until resp_ready, then go to IDLE.
  - flush: clear resp_valid, go to IDLE. flush wins over resp_ready.
- FSM DRAIN: on data_ok go to IDLE; resp_valid stays 0.
- data_ok in IDLE or REQ is ignored; the bus never returns data_ok in the addr_ok cycle.
- At most one outstanding transaction. No new request until the previous one is in IDLE.
- Minimum load latency: in_valid at cycle 0, req at 1. With addr_ok at 1, in_ready = 1 at 1 and WAIT at 2. With data_ok at 2, resp_valid = 1 at 3.
- Reset asserted mid-transaction returns to IDLE immediately; the bus is reset alongside.

Test Plan:
- Load word, paddr 0x1C00_0104, rdata 0x8765_4321, addr_ok/data_ok asserted when expected -> req at cycle 1 with wstrb 0, resp_valid at cycle 3, resp_rdata = 0x8765_4321.
- Load byte signed at paddr ...03, rdata 0x80xx_xxxx -> resp_rdata = 0xFFFF_FF80. Same with in_uns = 1 -> 0x0000_0080.
- Store half, paddr ...02, wdata 0x0000_BEEF -> wstrb = 4'b1100, data_sram_wdata = 0xBEEF_BEEF, wr = 1, size = 1.
- Load word at paddr ...02 -> ale = 1 and in_ready = 1 in cycle 0, req never rises. Repeat with in_ex = 1 on aligned address -> no req, ale = 0.
- addr_ok delayed 3 cycles with flush in the 2nd req cycle -> req/addr/wstrb stable until addr_ok. Then DRAIN; data_ok is swallowed, resp_valid never asserts, busy falls after data_ok.
- resp_ready held low for 4 cycles -> resp_valid and resp_rdata held. A new in_valid is not accepted (no req) until resp_ready. Flush in RESP -> resp_valid = 0 next cycle.

Source files
------------

// File: rtl/mem_req_issue_if.sv
// Interface bundling the EX-side request, MEM-side response and SRAM-like data bus
// of the data memory request issuer.
interface mem_req_issue_if;
  logic        in_valid;
  logic        in_we;
  logic [1:0]  in_size;
  logic        in_uns;
  logic [31:0] in_paddr;
  logic [31:0] in_wdata;
  logic        in_ex;
  logic        flush;
  logic        in_ready;
  logic        ale;
  logic        busy;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_ready;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  // Environment side: pipeline stages and the memory bus
  modport master (
    output in_valid, in_we, in_size, in_uns, in_paddr, in_wdata, in_ex, flush,
    output resp_ready, data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
    input  in_ready, ale, busy, resp_valid, resp_rdata,
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
    input  data_sram_addr, data_sram_wdata
  );

  modport slave (
    input  in_valid, in_we, in_size, in_uns, in_paddr, in_wdata, in_ex, flush,
    input  resp_ready, data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
    output in_ready, ale, busy, resp_valid, resp_rdata,
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
    output data_sram_addr, data_sram_wdata
  );
endinterface

// File: rtl/mem_req_issue.sv
// Data-side memory request issuer: alignment check, strobe/write-data generation,
// single-outstanding SRAM-like bus transaction and aligned/extended load return.
module mem_req_issue #(
  parameter bit ALE_EN = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  mem_req_issue_if.slave io
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic        cancel_q, cancel_d;
  logic        uns_q, uns_d;
  logic        req_q, req_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        misaligned_s;
  logic        ale_s;
  logic        in_ready_s;

  function automatic logic [3:0] gen_wstrb(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    gen_wstrb = 4'b0001 << off;
      2'd1:    gen_wstrb = 4'b0011 << {off[1], 1'b0};
      default: gen_wstrb = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] gen_wdata(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      2'd0:    gen_wdata = {4{wdata[7:0]}};
      2'd1:    gen_wdata = {2{wdata[15:0]}};
      default: gen_wdata = wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_align(input logic [31:0] rdata, input logic [1:0] off,
                                             input logic [1:0] size, input logic uns);
    logic [31:0] sh;
    sh = rdata >> {off, 3'b000};
    case (size)
      2'd0:    load_align = uns ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'd1:    load_align = uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: load_align = rdata;
    endcase
  endfunction

  assign misaligned_s = ((io.in_size == 2'd1) && io.in_paddr[0]) ||
                        (io.in_size[1] && (io.in_paddr[1:0] != 2'b00));
  assign ale_s = ALE_EN && io.in_valid && !io.in_ex && misaligned_s &&
                 (state_q == S_IDLE) && !io.flush;

  // Next-state, latched request fields and response capture
  always_comb begin
    state_d      = state_q;
    cancel_d     = cancel_q;
    uns_d        = uns_q;
    req_d        = req_q;
    wr_d         = wr_q;
    size_d       = size_q;
    wstrb_d      = wstrb_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    in_ready_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (io.flush) begin
          in_ready_s = 1'b0;
        end else if (io.in_valid && (io.in_ex || ale_s)) begin
          in_ready_s = 1'b1;
        end else if (io.in_valid) begin
          req_d    = 1'b1;
          wr_d     = io.in_we;
          size_d   = io.in_size[1] ? 2'd2 : io.in_size;
          wstrb_d  = io.in_we ? gen_wstrb(io.in_size, io.in_paddr[1:0]) : 4'b0000;
          addr_d   = io.in_paddr;
          wdata_d  = io.in_we ? gen_wdata(io.in_size, io.in_wdata) : 32'd0;
          uns_d    = io.in_uns;
          cancel_d = 1'b0;
          state_d  = S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        in_ready_s = io.data_sram_addr_ok;
        if (io.data_sram_addr_ok) begin
          // The request cannot be withdrawn, so a flush only redirects the reply
          req_d    = 1'b0;
          state_d  = (cancel_q || io.flush) ? S_DRAIN : S_WAIT;
          cancel_d = 1'b0;
        end else begin
          cancel_d = cancel_q || io.flush;
        end
      end
      S_WAIT: begin
        if (io.flush) begin
          state_d = io.data_sram_data_ok ? S_IDLE : S_DRAIN;
        end else if (io.data_sram_data_ok) begin
          resp_valid_d = 1'b1;
          resp_rdata_d = wr_q ? 32'd0 : load_align(io.data_sram_rdata, addr_q[1:0], size_q, uns_q);
          state_d      = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RESP: begin
        if (io.flush || io.resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      S_DRAIN: begin
        if (io.data_sram_data_ok) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d      = S_IDLE;
        req_d        = 1'b0;
        resp_valid_d = 1'b0;
      end
    endcase
  end

  // State and registered bus/response outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cancel_q     <= 1'b0;
      uns_q        <= 1'b0;
      req_q        <= 1'b0;
      wr_q         <= 1'b0;
      size_q       <= 2'd0;
      wstrb_q      <= 4'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      cancel_q     <= cancel_d;
      uns_q        <= uns_d;
      req_q        <= req_d;
      wr_q         <= wr_d;
      size_q       <= size_d;
      wstrb_q      <= wstrb_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign io.in_ready        = in_ready_s;
  assign io.ale             = ale_s;
  assign io.busy            = (state_q != S_IDLE);
  assign io.resp_valid      = resp_valid_q;
  assign io.resp_rdata      = resp_rdata_q;
  assign io.data_sram_req   = req_q;
  assign io.data_sram_wr    = wr_q;
  assign io.data_sram_size  = size_q;
  assign io.data_sram_wstrb = wstrb_q;
  assign io.data_sram_addr  = addr_q;
  assign io.data_sram_wdata = wdata_q;

endmodule
